// File: rtl/sample_scheduler.sv
// rtl/sample_scheduler.sv - round-robin sample bus sequencer with FWFT capture FIFO
// Polls enabled pin controllers in turn and queues marker-valid sample words for the host.
module sample_scheduler #(
  parameter logic [7:0] POSITION     = 8'd240,
  parameter int         NUM_CHANNELS = 8,
  parameter int         FIFO_AW      = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [18:0]        addr,
  input  logic               data_wr,
  input  logic               data_rd,
  input  logic [31:0]        data_in,
  output logic [15:0]        data_out,
  output logic               output_sample,
  output logic [7:0]         channel_select,
  input  logic [31:0]        sample_data,
  input  logic               fifo_rd,
  output logic [31:0]        fifo_data,
  output logic               fifo_empty,
  output logic [FIFO_AW:0]   fifo_count
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SWEEP   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_WAIT    = 2'd3;

  localparam int              DEPTH      = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(DEPTH);
  localparam logic [31:0]     CH_MASK    = 32'hFFFF_FFFF >> (32 - NUM_CHANNELS);
  localparam logic [4:0]      LAST_CH    = 5'(NUM_CHANNELS - 1);

  logic [1:0]  state;
  logic [4:0]  ch;
  logic [31:0] mask;
  logic [31:0] div;
  logic [31:0] div_cnt;
  logic        start_q;
  logic [15:0] overflow_cnt;
  logic [15:0] marker_err_cnt;
  logic        overflow_seen;

  logic [31:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;

  logic sel, reg_wr, cmd_start, cmd_stop, cmd_clear;
  logic running, full, empty, last_ch, mask_hit;
  logic capture, marker_ok, push, pop;
  logic addr_unused;

  assign addr_unused = ^addr[18:16];

  assign sel       = enable && (addr[15:8] == POSITION);
  assign reg_wr    = sel && data_wr;
  assign cmd_start = reg_wr && (addr[7:0] == 8'd0) && (data_in == 32'd1);
  assign cmd_stop  = reg_wr && (addr[7:0] == 8'd0) && (data_in == 32'd2);
  assign cmd_clear = reg_wr && (addr[7:0] == 8'd0) && (data_in == 32'd3);

  assign running  = (state != S_IDLE);
  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign last_ch  = (ch == LAST_CH);
  assign mask_hit = mask[ch];

  // A STOP landing on the capture edge discards the word in flight.
  assign capture   = (state == S_CAPTURE) && !cmd_stop;
  assign marker_ok = (sample_data[15:1] == 15'h55E7);
  assign push      = capture && marker_ok && !full;
  assign pop       = fifo_rd && !empty;

  assign output_sample  = (state == S_SWEEP) && mask_hit;
  assign channel_select = {3'b000, ch};
  assign fifo_data      = empty ? 32'd0 : mem[rd_ptr];
  assign fifo_empty     = empty;
  assign fifo_count     = count;

  always_ff @(posedge clk) begin
    if (reset) begin
      mask <= '0;
      div  <= '0;
    end else if (reg_wr) begin
      if (addr[7:0] == 8'd1) mask <= data_in & CH_MASK;
      if (addr[7:0] == 8'd2) div  <= data_in;
    end
  end

  // START is registered before IDLE acts on it; STOP takes effect on its own edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      ch      <= '0;
      div_cnt <= '0;
      start_q <= 1'b0;
    end else begin
      start_q <= cmd_start && (state == S_IDLE);
      if (cmd_stop) begin
        state <= S_IDLE;
        ch    <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_q) begin
              state <= S_SWEEP;
              ch    <= '0;
            end
          end
          S_WAIT: begin
            if (div_cnt == '0) begin
              state <= S_SWEEP;
              ch    <= '0;
            end else begin
              div_cnt <= div_cnt - 32'd1;
            end
          end
          S_SWEEP: begin
            if (mask_hit) begin
              state <= S_CAPTURE;
            end else if (last_ch) begin
              state   <= S_WAIT;
              div_cnt <= div;
              ch      <= '0;
            end else begin
              ch <= ch + 5'd1;
            end
          end
          default: begin
            if (last_ch) begin
              state   <= S_WAIT;
              div_cnt <= div;
              ch      <= '0;
            end else begin
              state <= S_SWEEP;
              ch    <= ch + 5'd1;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || cmd_clear) begin
      overflow_cnt   <= '0;
      marker_err_cnt <= '0;
      overflow_seen  <= 1'b0;
    end else if (capture) begin
      if (!marker_ok) begin
        if (marker_err_cnt != 16'hFFFF) marker_err_cnt <= marker_err_cnt + 16'd1;
      end else if (full) begin
        overflow_seen <= 1'b1;
        if (overflow_cnt != 16'hFFFF) overflow_cnt <= overflow_cnt + 16'd1;
      end
    end
  end

  // Fullness is judged before the pop, so a push into a full FIFO is lost even with fifo_rd.
  always_ff @(posedge clk) begin
    if (reset || cmd_clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sample_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= '0;
    end else if (sel && data_rd) begin
      case (addr[7:0])
        8'd8:    data_out <= {12'b0, running, full, empty, overflow_seen};
        8'd9:    data_out <= 16'(count);
        8'd10:   data_out <= overflow_cnt;
        8'd11:   data_out <= marker_err_cnt;
        default: data_out <= '0;
      endcase
    end else begin
      data_out <= '0;
    end
  end

endmodule

// File: tb/tb_sample_scheduler.sv
// tb/tb_sample_scheduler.sv - directed self-checking bench for sample_scheduler
// A small pin-controller model answers each request one cycle later with a tagged marker word.
module tb_sample_scheduler;

  localparam logic [7:0] POS = 8'd240;

  logic        clk = 1'b0;
  logic        reset, enable, data_wr, data_rd, fifo_rd;
  logic [18:0] addr;
  logic [31:0] data_in;
  logic [15:0] data_out;
  logic        output_sample;
  logic [7:0]  channel_select;
  logic [31:0] sample_data;
  logic [31:0] fifo_data;
  logic        fifo_empty;
  logic [6:0]  fifo_count;

  logic [11:0] cnt;
  logic        cnt_clr;
  logic [7:0]  bad_ch;

  int n_checks = 0;
  int n_fails  = 0;
  int t, gap2, n;
  logic [15:0] v;

  sample_scheduler dut (
    .clk(clk), .reset(reset), .enable(enable), .addr(addr),
    .data_wr(data_wr), .data_rd(data_rd), .data_in(data_in), .data_out(data_out),
    .output_sample(output_sample), .channel_select(channel_select),
    .sample_data(sample_data), .fifo_rd(fifo_rd), .fifo_data(fifo_data),
    .fifo_empty(fifo_empty), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Word = {channel, request number, 0xABC marker, 3'b111, 0}; bad channels answer 0.
  always @(posedge clk) begin
    if (cnt_clr) cnt <= '0;
    else if (output_sample) cnt <= cnt + 12'd1;
    if (output_sample && !bad_ch[channel_select[2:0]])
      sample_data <= {channel_select[3:0], cnt, 16'hABCE};
    else
      sample_data <= 32'h0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] r, input logic [31:0] d);
    enable = 1'b1; data_wr = 1'b1; addr = {3'b000, POS, r}; data_in = d;
    tick();
    enable = 1'b0; data_wr = 1'b0; addr = '0; data_in = '0;
  endtask

  task automatic rd(input logic [7:0] slot, input logic [7:0] r, output logic [15:0] val);
    enable = 1'b1; data_rd = 1'b1; addr = {3'b000, slot, r};
    tick();
    val = data_out;
    enable = 1'b0; data_rd = 1'b0; addr = '0;
  endtask

  task automatic pop();
    fifo_rd = 1'b1;
    tick();
    fifo_rd = 1'b0;
  endtask

  task automatic clr_cnt();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; data_wr = 1'b0; data_rd = 1'b0; fifo_rd = 1'b0;
    addr = '0; data_in = '0; cnt_clr = 1'b1; bad_ch = 8'h00;
    tick(); tick();
    reset = 1'b0; cnt_clr = 1'b0;

    chk("rst_data_out", data_out, 0);
    chk("rst_output_sample", output_sample, 0);
    chk("rst_channel_select", channel_select, 0);
    chk("rst_fifo_empty", fifo_empty, 1);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_fifo_data", fifo_data, 0);
    rd(POS, 8'd8, v);
    chk("rst_status", v, 16'h0002);

    // Two of eight channels, DIV=10: period 8+2+10+1
    wr(8'd1, 32'h05); wr(8'd2, 32'd10); wr(8'd0, 32'd1);
    tick();
    chk("a_first_req", output_sample, 1);
    chk("a_first_ch", channel_select, 0);
    t = 0; gap2 = 0;
    do begin
      tick(); t++;
      if (output_sample && channel_select == 8'd2 && gap2 == 0) gap2 = t;
    end while (!(output_sample && channel_select == 8'd0) && t < 60);
    chk("a_ch2_gap", gap2, 3);
    chk("a_sweep_period", t, 21);
    wr(8'd0, 32'd2);
    chk("a_stop_no_req", output_sample, 0);
    rd(POS, 8'd8, v);
    chk("a_status_stopped", v, 16'h0000);
    rd(POS, 8'd9, v);
    chk("a_count_reg", v, 2);
    rd(8'd239, 8'd9, v);
    chk("a_unselected_read", v, 0);
    chk("a_head0", fifo_data, 32'h0000_ABCE);
    pop();
    chk("a_head1", fifo_data, 32'h2001_ABCE);
    pop();
    chk("a_empty", fifo_empty, 1);
    pop();
    chk("a_pop_empty_ignored", fifo_count, 0);

    // Channel 1 returns no marker
    bad_ch = 8'h02;
    wr(8'd1, 32'h02); wr(8'd2, 32'd0); wr(8'd0, 32'd1);
    for (int k = 1; k <= 3; k++) begin
      t = 0;
      while (!output_sample && t < 40) begin tick(); t++; end
      chk("b_req_ch1", channel_select, 1);
      tick(); tick();
      rd(POS, 8'd11, v);
      chk("b_marker_err_cnt", v, k);
    end
    chk("b_no_push", fifo_count, 0);
    wr(8'd0, 32'd2); wr(8'd0, 32'd3);
    bad_ch = 8'h00;
    rd(POS, 8'd11, v);
    chk("b_clear_marker_cnt", v, 0);

    // Fill to 64, then overflow
    clr_cnt();
    wr(8'd1, 32'hFF); wr(8'd0, 32'd1);
    t = 0;
    while (fifo_count != 7'd64 && t < 400) begin tick(); t++; end
    chk("c_full_count", fifo_count, 64);
    while (!output_sample && t < 400) begin tick(); t++; end
    chk("c_req_after_full", channel_select, 0);
    tick(); tick();
    rd(POS, 8'd10, v);
    chk("c_ovf_cnt_1", v, 1);
    rd(POS, 8'd8, v);
    chk("c_status_full_ovf", v, 16'h000D);
    wr(8'd0, 32'd2);
    rd(POS, 8'd10, v);
    chk("c_ovf_cnt_2", v, 2);
    rd(POS, 8'd9, v);
    chk("c_count_reg_64", v, 64);
    chk("c_head", fifo_data, 32'h0000_ABCE);

    // Pop on the same cycle as a push into the full FIFO
    wr(8'd0, 32'd1);
    t = 0;
    while (!output_sample && t < 40) begin tick(); t++; end
    chk("d_req_ch0", channel_select, 0);
    tick();
    fifo_rd = 1'b1; tick(); fifo_rd = 1'b0;
    wr(8'd0, 32'd2);
    chk("d_count_63", fifo_count, 63);
    rd(POS, 8'd10, v);
    chk("d_ovf_cnt_3", v, 3);
    chk("d_head_order", fifo_data, 32'h1001_ABCE);

    // STOP on the CAPTURE edge of channel 3
    wr(8'd0, 32'd3);
    clr_cnt();
    wr(8'd1, 32'h0F); wr(8'd0, 32'd1);
    t = 0;
    while (!(output_sample && channel_select == 8'd3) && t < 60) begin tick(); t++; end
    chk("e_req_ch3", channel_select, 3);
    tick();
    wr(8'd0, 32'd2);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (output_sample) n++;
      tick();
    end
    chk("e_no_req_after_stop", n, 0);
    chk("e_count_3", fifo_count, 3);
    rd(POS, 8'd8, v);
    chk("e_running_0", v & 16'h0008, 0);
    chk("e_word0", fifo_data, 32'h0000_ABCE);
    pop();
    chk("e_word1", fifo_data, 32'h1001_ABCE);
    pop();
    chk("e_word2", fifo_data, 32'h2002_ABCE);

    // Push+pop together, then reset mid-sweep
    wr(8'd0, 32'd3);
    clr_cnt();
    wr(8'd1, 32'hFF); wr(8'd0, 32'd1);
    t = 0;
    while (fifo_count != 7'd5 && t < 100) begin tick(); t++; end
    chk("f_count_5", fifo_count, 5);
    tick();
    fifo_rd = 1'b1; tick(); fifo_rd = 1'b0;
    chk("f_push_pop_count", fifo_count, 5);
    chk("f_head_after_pop", fifo_data, 32'h1001_ABCE);
    chk("f_mid_sweep_req", output_sample, 1);
    reset = 1'b1;
    tick();
    chk("f_rst_empty", fifo_empty, 1);
    chk("f_rst_count", fifo_count, 0);
    chk("f_rst_output_sample", output_sample, 0);
    chk("f_rst_fifo_data", fifo_data, 0);
    reset = 1'b0;
    wr(8'd0, 32'd1);
    tick();
    rd(POS, 8'd8, v);
    chk("f_status_running_empty", v, 16'h000A);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (output_sample) n++;
      tick();
    end
    chk("f_mask_zero_no_req", n, 0);
    wr(8'd0, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
